// File: rtl/ip_sound_mixer_pkg.sv
// Shared types and constants for the sound mixer: FSM states, volume reset value,
// gain shift and the index that selects the mute register.
package ip_sound_mixer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_SAT,
      ST_OUT
   } mix_state_t;

   localparam logic [3:0] VOL_RESET  = 4'd8;
   localparam int         GAIN_SHIFT = 3;
   localparam logic [3:0] MUTE_INDEX = 4'hF;

endpackage

// File: rtl/ip_sound_level_meter.sv
// Peak-hold level meter with periodic decay; drives an active-low LED bar.
// Only instantiated by ip_sound_mixer when MIXER_LED_METER_EN is defined.
module ip_sound_level_meter #(
   parameter int OUT_W     = 16,
   parameter int LED_NUM   = 5,
   parameter int DECAY_CYC = 3579
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mclk_pcen_n,
   input  logic                    sound_valid,
   input  logic signed [OUT_W-1:0] sound_out,
   output logic [LED_NUM-1:0]      n_led
);

   localparam int PK_W  = OUT_W - 1;
   localparam int CNT_W = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;

   logic [PK_W-1:0]  peak_reg;
   logic [PK_W-1:0]  level;
   logic [CNT_W-1:0] decay_cnt_reg;
   logic             decay_hit;

   // Magnitude of the sample; the most negative code clamps to the positive maximum.
   always_comb begin
      level = sound_out[PK_W-1:0];
      if (sound_out[OUT_W-1]) begin
         if (sound_out[PK_W-1:0] == '0)
            level = '1;
         else
            level = ~sound_out[PK_W-1:0] + 1'b1;
      end
   end

   assign decay_hit = !mclk_pcen_n && (decay_cnt_reg == CNT_W'(DECAY_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         peak_reg      <= '0;
         decay_cnt_reg <= '0;
      end else begin
         if (!mclk_pcen_n)
            decay_cnt_reg <= decay_hit ? '0 : decay_cnt_reg + 1'b1;
         // A new sample takes priority over a coincident decay step.
         if (sound_valid) begin
            if (level > peak_reg)
               peak_reg <= level;
         end else if (decay_hit) begin
            peak_reg <= peak_reg - (peak_reg >> 4);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LED_NUM; gi++) begin : g_led
         localparam logic [PK_W-1:0] THRESH = PK_W'(1) << (OUT_W - 1 - LED_NUM + gi);
         assign n_led[gi] = !(peak_reg >= THRESH);
      end
   endgenerate

endmodule

// File: rtl/ip_sound_mixer.sv
// Multi-channel sound mixer with MSX I/O-port volume/mute control and saturation.
// Define MIXER_LED_METER_EN to build the peak level meter on n_led.
module ip_sound_mixer
   import ip_sound_mixer_pkg::*;
#(
   parameter int         CH_NUM    = 4,
   parameter int         IN_W      = 11,
   parameter int         OUT_W     = 16,
   parameter int         LED_NUM   = 5,
   parameter logic [7:0] IO_BASE   = 8'hDC,
   parameter int         DECAY_CYC = 3579
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mclk_pcen_n,
   input  logic                     n_tiorq,
   input  logic                     n_twr,
   input  logic [7:0]               ta,
   input  logic [7:0]               wdata,
   input  logic [CH_NUM*IN_W-1:0]   ch_in,
   output logic signed [OUT_W-1:0]  sound_out,
   output logic                     sound_valid,
   output logic [LED_NUM-1:0]       n_led
);

   localparam int ACC_W = IN_W + 4 + $clog2(CH_NUM);
   localparam int IDX_W = $clog2(CH_NUM);
   localparam int CW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
   localparam logic signed [CW-1:0] SAT_MAX = (CW'(1) << (OUT_W - 1)) - CW'(1);
   localparam logic signed [CW-1:0] SAT_MIN = -SAT_MAX - CW'(1);

   logic                    n_twr_prev_reg;
   logic                    wr_fire;
   logic [3:0]              index_reg;
   logic                    mute_reg;
   logic                    unused_wdata;
   logic signed [IN_W-1:0]  ch_arr     [CH_NUM];
   logic [3:0]              vol_arr    [CH_NUM];
   logic signed [IN_W-1:0]  ch_snap_reg[CH_NUM];
   logic [3:0]              vol_snap_reg[CH_NUM];
   logic                    mute_snap_reg;
   mix_state_t              state_reg;
   logic [IDX_W-1:0]        ch_cnt_reg;
   logic signed [ACC_W-1:0] acc_reg;
   logic signed [IN_W+4:0]  prod;
   logic signed [ACC_W-1:0] shifted;
   logic signed [CW-1:0]    shifted_ext;
   logic signed [OUT_W-1:0] sat_val;
   logic signed [OUT_W-1:0] sat_reg;
   logic signed [OUT_W-1:0] sound_out_reg;
   logic                    sound_valid_reg;

   // A write is recognised only on the falling edge of n_twr.
   assign wr_fire      = !n_twr && n_twr_prev_reg && !n_tiorq && (ta[7:1] == IO_BASE[7:1]);
   assign unused_wdata = ^wdata[7:4];

   always_ff @(posedge clk) begin
      if (reset) begin
         n_twr_prev_reg <= 1'b1;
         index_reg      <= '0;
         mute_reg       <= 1'b0;
      end else begin
         n_twr_prev_reg <= n_twr;
         if (wr_fire && !ta[0])
            index_reg <= wdata[3:0];
         if (wr_fire && ta[0] && index_reg == MUTE_INDEX)
            mute_reg <= wdata[0];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
         logic [3:0] vol_reg;
         assign ch_arr[gi]  = ch_in[gi*IN_W +: IN_W];
         assign vol_arr[gi] = vol_reg;
         always_ff @(posedge clk) begin
            if (reset)
               vol_reg <= VOL_RESET;
            else if (wr_fire && ta[0] && index_reg == 4'(gi))
               vol_reg <= wdata[3:0];
         end
      end
   endgenerate

   // Signed sample times unsigned 4-bit volume.
   assign prod = $signed({{5{ch_snap_reg[ch_cnt_reg][IN_W-1]}}, ch_snap_reg[ch_cnt_reg]})
               * $signed({{IN_W{1'b0}}, 1'b0, vol_snap_reg[ch_cnt_reg]});

   assign shifted     = acc_reg >>> GAIN_SHIFT;
   assign shifted_ext = CW'(shifted);

   always_comb begin
      if (shifted_ext > SAT_MAX)
         sat_val = {1'b0, {(OUT_W-1){1'b1}}};
      else if (shifted_ext < SAT_MIN)
         sat_val = {1'b1, {(OUT_W-1){1'b0}}};
      else
         sat_val = shifted_ext[OUT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         ch_cnt_reg      <= '0;
         acc_reg         <= '0;
         sat_reg         <= '0;
         mute_snap_reg   <= 1'b0;
         sound_out_reg   <= '0;
         sound_valid_reg <= 1'b0;
      end else begin
         sound_valid_reg <= 1'b0;
         unique case (state_reg)
            ST_IDLE: begin
               if (!mclk_pcen_n) begin
                  ch_snap_reg   <= ch_arr;
                  vol_snap_reg  <= vol_arr;
                  mute_snap_reg <= mute_reg;
                  acc_reg       <= '0;
                  ch_cnt_reg    <= '0;
                  state_reg     <= ST_ACC;
               end
            end
            ST_ACC: begin
               acc_reg    <= acc_reg + ACC_W'(prod);
               ch_cnt_reg <= ch_cnt_reg + 1'b1;
               if (ch_cnt_reg == IDX_W'(CH_NUM - 1))
                  state_reg <= ST_SAT;
            end
            ST_SAT: begin
               sat_reg   <= sat_val;
               state_reg <= ST_OUT;
            end
            ST_OUT: begin
               sound_out_reg   <= mute_snap_reg ? '0 : sat_reg;
               sound_valid_reg <= 1'b1;
               state_reg       <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign sound_out   = sound_out_reg;
   assign sound_valid = sound_valid_reg;

`ifdef MIXER_LED_METER_EN
   ip_sound_level_meter #(
      .OUT_W     (OUT_W),
      .LED_NUM   (LED_NUM),
      .DECAY_CYC (DECAY_CYC)
   ) u_meter (
      .clk         (clk),
      .reset       (reset),
      .mclk_pcen_n (mclk_pcen_n),
      .sound_valid (sound_valid_reg),
      .sound_out   (sound_out_reg),
      .n_led       (n_led)
   );
`else
   assign n_led = '1;
`endif

endmodule

// File: tb/tb_ip_sound_mixer.sv
// Randomised self-checking bench for ip_sound_mixer against an arithmetic mix model.
module tb_ip_sound_mixer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, mclk_pcen_n, n_tiorq, n_twr;
   logic [7:0]  ta, wdata;
   logic [43:0] ch_in_d, ch_in_s;
   logic [59:0] ch_in_m;
   logic signed [15:0] so_d, so_m;
   logic signed [11:0] so_s;
   logic        sv_d, sv_s, sv_m;
   logic [4:0]  led_d, led_s, led_m;

   int checks = 0;
   int failures = 0;
   int vol_m[4];
   int idx_m, mute_m;

   ip_sound_mixer dut (
      .clk(clk), .reset(reset), .mclk_pcen_n(mclk_pcen_n), .n_tiorq(n_tiorq), .n_twr(n_twr),
      .ta(ta), .wdata(wdata), .ch_in(ch_in_d), .sound_out(so_d), .sound_valid(sv_d), .n_led(led_d));

   ip_sound_mixer #(.OUT_W(12)) dut_s (
      .clk(clk), .reset(reset), .mclk_pcen_n(mclk_pcen_n), .n_tiorq(n_tiorq), .n_twr(n_twr),
      .ta(ta), .wdata(wdata), .ch_in(ch_in_s), .sound_out(so_s), .sound_valid(sv_s), .n_led(led_s));

   ip_sound_mixer #(.IN_W(15), .DECAY_CYC(4)) dut_m (
      .clk(clk), .reset(reset), .mclk_pcen_n(mclk_pcen_n), .n_tiorq(n_tiorq), .n_twr(n_twr),
      .ta(ta), .wdata(wdata), .ch_in(ch_in_m), .sound_out(so_m), .sound_valid(sv_m), .n_led(led_m));

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 4; k++) vol_m[k] = 8;
      idx_m  = 0;
      mute_m = 0;
   endfunction

   function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
      if (a == 8'hDC) idx_m = int'(d[3:0]);
      else if (a == 8'hDD) begin
         if (idx_m < 4) vol_m[idx_m] = int'(d[3:0]);
         else if (idx_m == 15) mute_m = int'(d[0]);
      end
   endfunction

   // Gain is vol/8 with floor rounding, then clamp to the output range.
   function automatic longint mix_ref(input int c[4], input int out_w);
      longint s, q, hi, lo;
      s = 0;
      for (int k = 0; k < 4; k++) s += longint'(c[k]) * longint'(vol_m[k]);
      q = s / 8;
      if (s < 0 && (s % 8) != 0) q = q - 1;
      hi = (longint'(1) << (out_w - 1)) - 1;
      lo = -hi - 1;
      if (q > hi) q = hi;
      if (q < lo) q = lo;
      return (mute_m != 0) ? 0 : q;
   endfunction

   function automatic longint led_ref(input int pk);
      longint r;
      r = 5'h1F;
`ifdef MIXER_LED_METER_EN
      for (int i = 0; i < 5; i++)
         if (pk >= (1 << (10 + i))) r[i] = 1'b0;
`endif
      return r;
   endfunction

   task automatic set_ch(input int c[4]);
      for (int k = 0; k < 4; k++) begin
         ch_in_d[k*11 +: 11] = 11'(c[k]);
         ch_in_s[k*11 +: 11] = 11'(c[k]);
         ch_in_m[k*15 +: 15] = 15'(c[k]);
      end
   endtask

   task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
      @(posedge clk); #1;
      ta = addr; wdata = data; n_tiorq = 1'b0; n_twr = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_twr = 1'b1; n_tiorq = 1'b1;
      model_write(addr, data);
   endtask

   // Strobe once, optionally write IO_BASE+1 while the mix runs; lat = clks from strobe to valid.
   task automatic run_mix(input bit mid_wr, input logic [3:0] wr_val, output int lat);
      lat = -1;
      @(posedge clk); #1 mclk_pcen_n = 1'b0;
      @(posedge clk); #1 mclk_pcen_n = 1'b1;
      if (mid_wr) begin
         ta = 8'hDD; wdata = {4'h0, wr_val}; n_tiorq = 1'b0; n_twr = 1'b0;
      end
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c == 2) begin
            n_twr = 1'b1; n_tiorq = 1'b1;
            if (mid_wr) model_write(8'hDD, {4'h0, wr_val});
         end
         if (sv_d) begin
            lat = c;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c[4];
      int lat, pulses, pk, strobes, decays;
      longint e, es;

      reset = 1'b1; mclk_pcen_n = 1'b1; n_tiorq = 1'b1; n_twr = 1'b1; ta = '0; wdata = '0;
      ch_in_d = '0; ch_in_s = '0; ch_in_m = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_out", so_d, 0);
      chk("rst_valid", sv_d, 0);
      chk("rst_led", led_m, 5'h1F);

      // Unity gain, both polarities.
      c = '{100, 0, 0, 0}; set_ch(c); e = mix_ref(c, 16);
      run_mix(1'b0, 4'h0, lat);
      chk("unity_lat", lat, 6);
      chk("unity_pos", so_d, e);
      @(posedge clk); #1;
      chk("valid_pulse", sv_d, 0);
      chk("out_hold", so_d, e);
      c = '{-100, 0, 0, 0}; set_ch(c); e = mix_ref(c, 16);
      run_mix(1'b0, 4'h0, lat);
      chk("unity_neg", so_d, e);

      // Volume write, then an ignored index.
      io_write(8'hDC, 8'h02); io_write(8'hDD, 8'h04);
      c = '{0, 0, 400, 0}; set_ch(c); e = mix_ref(c, 16);
      run_mix(1'b0, 4'h0, lat);
      chk("vol_ch2", so_d, e);
      io_write(8'hDC, 8'h07); io_write(8'hDD, 8'h03);
      c = '{100, 0, 400, 0}; set_ch(c); e = mix_ref(c, 16);
      run_mix(1'b0, 4'h0, lat);
      chk("vol_idx7", so_d, e);

      // Saturation on the 12-bit instance.
      for (int k = 0; k < 4; k++) begin
         io_write(8'hDC, 8'(k)); io_write(8'hDD, 8'h0F);
      end
      c = '{1023, 1023, 1023, 1023}; set_ch(c);
      e = mix_ref(c, 16); es = mix_ref(c, 12);
      run_mix(1'b0, 4'h0, lat);
      chk("sat_hi_s", so_s, es);
      chk("sat_hi_valid_s", sv_s, 1);
      chk("sat_hi_d", so_d, e);
      c = '{-1024, -1024, -1024, -1024}; set_ch(c);
      e = mix_ref(c, 16); es = mix_ref(c, 12);
      run_mix(1'b0, 4'h0, lat);
      chk("sat_lo_s", so_s, es);
      chk("sat_lo_d", so_d, e);

      // Mute, then two strobes two clocks apart.
      io_write(8'hDC, 8'h0F); io_write(8'hDD, 8'h01);
      c = '{100, 0, 0, 0}; set_ch(c); e = mix_ref(c, 16);
      run_mix(1'b0, 4'h0, lat);
      chk("mute_lat", lat, 6);
      chk("mute_out", so_d, e);
      io_write(8'hDD, 8'h00);
      c = '{300, 0, 0, 0}; set_ch(c); e = mix_ref(c, 16);
      @(posedge clk); #1 mclk_pcen_n = 1'b0;
      @(posedge clk); #1 mclk_pcen_n = 1'b1;
      @(posedge clk); #1 mclk_pcen_n = 1'b0;
      @(posedge clk); #1 mclk_pcen_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (sv_d) pulses++;
      end
      chk("overlap_pulses", pulses, 1);
      chk("overlap_out", so_d, e);

      // Random mixes with register traffic, some of it landing mid-mix.
      for (int t = 0; t < 30; t++) begin
         int op;
         bit mid;
         logic [3:0] mv;
         op = int'($urandom_range(0, 9));
         if (op <= 6) begin
            io_write(8'hDC, 8'($urandom_range(0, 3))); io_write(8'hDD, 8'($urandom_range(0, 15)));
         end else if (op == 7) begin
            io_write(8'hDC, 8'($urandom_range(4, 14))); io_write(8'hDD, 8'($urandom_range(0, 15)));
         end else if (op == 8) begin
            io_write(8'hDC, 8'h0F); io_write(8'hDD, 8'($urandom_range(0, 1)));
         end
         for (int k = 0; k < 4; k++) c[k] = int'($urandom_range(0, 2047)) - 1024;
         set_ch(c);
         e = mix_ref(c, 16); es = mix_ref(c, 12);
         mid = ($urandom_range(0, 3) == 0);
         mv = 4'($urandom_range(0, 15));
         run_mix(mid, mv, lat);
         $display("txn %0d ch=%0d,%0d,%0d,%0d mute=%0d mid_wr=%0d out=%0d exp=%0d out12=%0d exp12=%0d",
                  t, c[0], c[1], c[2], c[3], mute_m, mid, so_d, e, so_s, es);
         chk("rand_lat", lat, 6);
         chk("rand_out", so_d, e);
         chk("rand_out12", so_s, es);
      end

      // Reset in the middle of the accumulate phase.
      io_write(8'hDC, 8'h0F); io_write(8'hDD, 8'h00);
      io_write(8'hDC, 8'h00); io_write(8'hDD, 8'h04);
      c = '{100, 0, 0, 0}; set_ch(c); e = mix_ref(c, 16);
      run_mix(1'b0, 4'h0, lat);
      chk("pre_reset_out", so_d, e);
      @(posedge clk); #1 mclk_pcen_n = 1'b0;
      @(posedge clk); #1 mclk_pcen_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      model_reset();
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (sv_d) pulses++;
      end
      chk("reset_no_valid", pulses, 0);
      chk("reset_out", so_d, 0);
      e = mix_ref(c, 16);
      run_mix(1'b0, 4'h0, lat);
      chk("reset_vol8", so_d, e);

      // Level meter: full-scale peak then 16 decay steps.
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      model_reset();
      pk = 0; strobes = 0; decays = 0;
      c = '{8192, 8192, 0, 0}; set_ch(c); e = mix_ref(c, 16);
      run_mix(1'b0, 4'h0, lat);
      strobes++;
      chk("meter_out", so_m, e);
      if (e > pk) pk = int'(e);
      @(posedge clk); #1;
      chk("meter_full", led_m, led_ref(pk));
      c = '{0, 0, 0, 0}; set_ch(c);
      while (decays < 16 && strobes < 200) begin
         run_mix(1'b0, 4'h0, lat);
         strobes++;
         if (strobes % 4 == 0) begin
            pk = pk - pk / 16;
            decays++;
            chk("meter_decay", led_m, led_ref(pk));
         end
      end
      chk("meter_final", led_m, led_ref(pk));
      chk("led_default_inst", led_s, led_ref(0) | 5'h1F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ip_sound_mixer.md
IP_SOUND_MIXER -- requirements
Module: ip_sound_mixer

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of mixed channels (legal range 2..8).
REQ-002 SHALL have parameter IN_W, default 11, signed width of each channel input.
REQ-003 SHALL have parameter OUT_W, default 16, signed width of sound_out.
REQ-004 SHALL have parameter LED_NUM, default 5, meter LED count (LED_NUM <= OUT_W-2).
REQ-005 SHALL have parameter IO_BASE, default 8'hDC, I/O port pair base address.
REQ-006 SHALL have parameter DECAY_CYC, default 3579, sample strobes per peak-decay step.
REQ-007 Ports SHALL be:
- clk  in  1  single clock; the block has one clock.
- reset  in  1  reset; synchronous, active-high.
- mclk_pcen_n  in  1  sample strobe, active low for one clk.
- n_tiorq  in  1  MSX I/O request, active low.
- n_twr  in  1  MSX write strobe, active low.
- ta  in  8  I/O address.
- wdata  in  8  write data.
- ch_in  in  CH_NUM*IN_W  packed signed channel samples; channel k is at [k*IN_W +: IN_W].
- sound_out  out  OUT_W  signed mixed sample.
- sound_valid  out  1  one-clk pulse when sound_out updates.
- n_led  out  LED_NUM  level meter, active low.

Function
REQ-008 Write detect SHALL fire once per write, on the first clk where n_twr=0, n_tiorq=0 and ta[7:1]=IO_BASE[7:1], using the registered previous n_twr.
REQ-009 Port IO_BASE SHALL latch wdata[3:0] into a 4-bit index register.
REQ-010 Port IO_BASE+1 SHALL act on the current index:
- index < CH_NUM: write volume[index] <= wdata[3:0].
- index = 4'hF: write mute <= wdata[0].
- any other index: ignore the write.
REQ-011 FSM states SHALL be IDLE, ACC, SAT, OUT.
- IDLE: on mclk_pcen_n=0, snapshot ch_in and all volumes, clear acc, go to ACC.
- ACC: runs CH_NUM clks, channel k in clk k: acc += ch[k]*vol[k] (signed x unsigned).
- SAT: computes acc >>> 3, then saturates to OUT_W (max 2^(OUT_W-1)-1, min -2^(OUT_W-1)).
- OUT: sound_out <= mute ? 0 : saturated value; sound_valid=1; return to IDLE.
REQ-012 acc width SHALL be IN_W+4+clog2(CH_NUM); gain is vol/8, so vol 8 = unity.
REQ-013 Latency SHALL be CH_NUM+2 clks from the strobe clk to the sound_valid clk.
REQ-014 A strobe arriving outside IDLE SHALL be dropped; the mix in progress SHALL be unaffected.
REQ-015 Register writes during ACC/SAT/OUT SHALL NOT affect the current mix (snapshot rule).
REQ-016 sound_out SHALL hold its value between sound_valid pulses.

Reset
REQ-017 While reset=1 at a clk edge, the block SHALL set:
- volumes = 8, index = 0, mute = 0.
- FSM = IDLE, acc = 0.
- sound_out = 0, sound_valid = 0.
- peak = 0, decay counter = 0, n_led = all ones.
REQ-018 Reset asserted mid-mix SHALL abort the mix with no sound_valid pulse.

Configuration
REQ-019 With MIXER_LED_METER_EN defined, the level meter SHALL work as follows:
- On each sound_valid: peak <= max(peak, |sound_out|), with |-2^(OUT_W-1)| clamped to 2^(OUT_W-1)-1.
- Every DECAY_CYC strobes: peak <= peak - (peak>>4).
- If both happen in the same clk, the max update wins.
- n_led[i] = 0 iff peak >= 2^(OUT_W-1-LED_NUM+i).
REQ-020 Without MIXER_LED_METER_EN, no peak or decay logic SHALL exist and n_led SHALL be constant all ones.

Structure
REQ-021 A shared package SHALL hold the FSM state typedef, the volume reset constant (8), the gain shift (3) and the mute index (4'hF).
REQ-022 The level meter SHALL be a sub-module ip_sound_level_meter, instantiated only under MIXER_LED_METER_EN.

Verification
REQ-023 The bench SHALL cover (defaults unless stated):
- Unity: ch0=100, others 0, reset volumes, strobe -> sound_valid 6 clks later, sound_out=100; repeat with ch0=-100 -> -100.
- Volume write: OUT 0xDC<=2, OUT 0xDD<=4, ch2=400 alone -> sound_out=200; index 7 write -> no volume changes.
- Saturation (OUT_W=12): all ch=1023, all vol=15 -> sound_out=2047; all ch=-1024 -> -2048.
- Mute and overlap: index 0xF, data 1 -> sound_out=0 with valid still pulsing; a second strobe 2 clks after the first -> only one valid pulse.
- Reset mid-mix: reset in ACC clk 2 -> no valid pulse, sound_out=0, volumes=8.
- Meter (macro on): sound_out=16384 -> n_led=5'b00000; after 16 decay steps with no input, peak = 16384*(15/16)^16 (truncated) and the LEDs light per REQ-019.
